leve1_wb: RTL

//  Writeback/commit end of the LEVE1 EX interface: consumes EX's registered result bus (valid, pc, instr, rd

---
 rtl/leve1_pkg.sv | 65 ++++++
 rtl/leve1_regfile.sv | 45 ++++
 rtl/leve1_wb.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/leve1_pkg.sv
// leve1_pkg: shared definitions for the LEVE1 writeback stage.
//   XLEN, machine-mode CSR addresses, CSR command encodings, privilege
//   modes, the mstatus view and the CSR read-modify-write helper.
`timescale 1ns/1ps
package leve1_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;

  localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] INSTR_MRET = 32'h30200073;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_cmd_e;

  typedef enum logic [1:0] {
    MODE_U    = 2'b00,
    MODE_S    = 2'b01,
    MODE_RSVD = 2'b10,
    MODE_M    = 2'b11
  } mode_e;

  typedef struct packed {
    logic [XLEN-14:0] hi;
    logic [1:0]       mpp;
    logic [10:0]      lo;
  } mstatus_s;

  typedef union packed {
    logic [XLEN-1:0] raw;
    mstatus_s        f;
  } mstatus_t;

  function automatic logic [XLEN-1:0] csr_apply(input csr_cmd_e        cmd,
                                                input logic [XLEN-1:0] old,
                                                input logic [XLEN-1:0] opnd);
    logic [XLEN-1:0] v;
    case (cmd)
      CSR_WRITE: v = opnd;
      CSR_SET:   v = old | opnd;
      CSR_CLEAR: v = old & ~opnd;
      default:   v = old;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/leve1_regfile.sv
// leve1_regfile: 31 x XLEN integer register file, two read ports, one
//   write port, asynchronous active-low reset. x0 is not stored and reads 0.
//   Reads see a same-cycle write (write-through bypass).
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   we_i, waddr_i, wdata_i write port
//   raddr1_i / rdata1_o    read port 1
//   raddr2_i / rdata2_o    read port 2
`timescale 1ns/1ps
module leve1_regfile
  import leve1_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  output logic [XLEN-1:0] rdata1_o,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [31:1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 1; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  function automatic logic [XLEN-1:0] rd_port(input logic [4:0] a);
    logic [XLEN-1:0] v;
    if (a == 5'd0)                 v = '0;
    else if (we_i && waddr_i == a) v = wdata_i;
    else                           v = regs_q[a];
    return v;
  endfunction

  always_comb rdata1_o = rd_port(raddr1_i);
  always_comb rdata2_o = rd_port(raddr2_i);

endmodule

// File: rtl/leve1_wb.sv
// leve1_wb: writeback/commit stage. Commits EX results to the integer
//   register file and the machine-mode CSR file, serves decode read ports
//   with same-cycle bypass, and issues the one-cycle MRET redirect to IF.
// Ports:
//   CLK, RSTn                     clock, async active-low reset
//   IVALID IPC IINSTR IWE IRD     retiring beat from EX
//   ICSRD                         csr operand / new mstatus on MRET
//   RS1_ADDR/RS1_DATA, RS2_ADDR/RS2_DATA, CSR_ADDR/CSR_DATA  read ports
//   OPC_WE ONEXT_PC OFLASH        redirect strobe, target, flush
//   OMODE                         current privilege mode
// Build option: define LEVE1_WB_COUNTERS_EN to implement mcycle/minstret
//   (with cycle/instret read aliases); otherwise those addresses read 0.
`timescale 1ns/1ps
module leve1_wb
  import leve1_pkg::*;
#(
  parameter logic [XLEN-1:0] HARTID      = '0,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter logic [XLEN-1:0] MISA_VALUE  = 64'h8000_0000_0000_0100
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            IVALID,
  input  logic [XLEN-1:0] IPC,
  input  logic [31:0]     IINSTR,
  input  logic            IWE,
  input  logic [XLEN-1:0] IRD,
  input  logic [XLEN-1:0] ICSRD,
  input  logic [4:0]      RS1_ADDR,
  output logic [XLEN-1:0] RS1_DATA,
  input  logic [4:0]      RS2_ADDR,
  output logic [XLEN-1:0] RS2_DATA,
  input  logic [11:0]     CSR_ADDR,
  output logic [XLEN-1:0] CSR_DATA,
  output logic            OPC_WE,
  output logic [XLEN-1:0] ONEXT_PC,
  output logic            OFLASH,
  output logic [1:0]      OMODE
);

  logic unused_ipc;
  assign unused_ipc = ^IPC;

  // ---------------- integer register file ----------------
  logic rf_we;
  assign rf_we = IVALID & IWE & (IINSTR[11:7] != 5'd0);

  leve1_regfile u_regfile (
    .clk_i    (CLK),
    .rst_ni   (RSTn),
    .we_i     (rf_we),
    .waddr_i  (IINSTR[11:7]),
    .wdata_i  (IRD),
    .raddr1_i (RS1_ADDR),
    .rdata1_o (RS1_DATA),
    .raddr2_i (RS2_ADDR),
    .rdata2_o (RS2_DATA)
  );

  // ---------------- CSR state ----------------
  mstatus_t        mstatus_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q;
  mode_e           mode_q, mode_d;
  logic            redir_q, redir_d;
  logic [XLEN-1:0] npc_q, npc_d;

  logic            is_mret;
  logic            csr_we;
  logic [11:0]     csr_addr;
  csr_cmd_e        cmd;
  logic [XLEN-1:0] csr_wdata;

`ifdef LEVE1_WB_COUNTERS_EN
  logic [XLEN-1:0] mcycle_q, minstret_q;

  // A CSR write to a counter replaces that cycle's increment.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= (csr_we && csr_addr == CSR_MCYCLE) ? csr_wdata
                    : mcycle_q + {{(XLEN-1){1'b0}}, 1'b1};
      minstret_q <= (csr_we && csr_addr == CSR_MINSTRET) ? csr_wdata
                    : minstret_q + {{(XLEN-1){1'b0}}, IVALID};
    end
  end
`else
  // No counter state: counter addresses fall to the read-zero default.
`endif

  function automatic logic [XLEN-1:0] csr_rd(input logic [11:0] addr);
    logic [XLEN-1:0] v;
    case (addr)
      CSR_MSTATUS:  v = mstatus_q.raw;
      CSR_MISA:     v = MISA_VALUE;
      CSR_MIE:      v = mie_q;
      CSR_MTVEC:    v = mtvec_q;
      CSR_MSCRATCH: v = mscratch_q;
      CSR_MEPC:     v = mepc_q;
      CSR_MCAUSE:   v = mcause_q;
      CSR_MTVAL:    v = mtval_q;
      CSR_MIP:      v = mip_q;
      CSR_MHARTID:  v = HARTID;
`ifdef LEVE1_WB_COUNTERS_EN
      CSR_MCYCLE,   CSR_CYCLE:   v = mcycle_q;
      CSR_MINSTRET, CSR_INSTRET: v = minstret_q;
`endif
      default:      v = '0;
    endcase
    return v;
  endfunction

  function automatic logic csr_writable(input logic [11:0] addr);
    logic w;
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
      CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP: w = 1'b1;
`ifdef LEVE1_WB_COUNTERS_EN
      CSR_MCYCLE, CSR_MINSTRET:                 w = 1'b1;
`endif
      default:                                  w = 1'b0;
    endcase
    return w;
  endfunction

  // User counter addresses are read aliases of the machine counters,
  // so a same-cycle write to the machine counter must bypass to them too.
  function automatic logic [11:0] csr_canon(input logic [11:0] addr);
    logic [11:0] a;
    case (addr)
      CSR_CYCLE:   a = CSR_MCYCLE;
      CSR_INSTRET: a = CSR_MINSTRET;
      default:     a = addr;
    endcase
    return a;
  endfunction

  always_comb begin
    is_mret  = IVALID && (IINSTR == INSTR_MRET);
    csr_addr = IINSTR[31:20];
    cmd      = csr_cmd_e'(IINSTR[13:12]);
    csr_we   = 1'b0;
    if (IVALID && IINSTR[6:0] == OPC_SYSTEM && IINSTR[14:12] != 3'b000) begin
      case (cmd)
        CSR_WRITE:          csr_we = 1'b1;
        CSR_SET, CSR_CLEAR: csr_we = (IINSTR[19:15] != 5'd0);
        default:            csr_we = 1'b0;
      endcase
    end
    csr_we    = csr_we && csr_writable(csr_addr);
    csr_wdata = csr_apply(cmd, csr_rd(csr_addr), ICSRD);
    if (csr_addr == CSR_MEPC) csr_wdata[1:0] = 2'b00;
  end

  always_comb begin
    CSR_DATA = csr_rd(CSR_ADDR);
    if (is_mret && CSR_ADDR == CSR_MSTATUS)        CSR_DATA = ICSRD;
    if (csr_we && csr_canon(CSR_ADDR) == csr_addr) CSR_DATA = csr_wdata;
  end

  // Redirect target is captured from mepc in the MRET cycle itself.
  always_comb begin
    redir_d = is_mret;
    npc_d   = is_mret ? mepc_q : npc_q;
    mode_d  = is_mret ? mode_e'(mstatus_q.f.mpp) : mode_q;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mip_q      <= '0;
      mode_q     <= MODE_M;
      redir_q    <= 1'b0;
      npc_q      <= '0;
    end else begin
      if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS:  mstatus_q.raw <= csr_wdata;
          CSR_MIE:      mie_q         <= csr_wdata;
          CSR_MTVEC:    mtvec_q       <= csr_wdata;
          CSR_MSCRATCH: mscratch_q    <= csr_wdata;
          CSR_MEPC:     mepc_q        <= csr_wdata;
          CSR_MCAUSE:   mcause_q      <= csr_wdata;
          CSR_MTVAL:    mtval_q       <= csr_wdata;
          CSR_MIP:      mip_q         <= csr_wdata;
          default:      ;
        endcase
      end
      if (is_mret) mstatus_q.raw <= ICSRD;
      mode_q  <= mode_d;
      redir_q <= redir_d;
      npc_q   <= npc_d;
    end
  end

  assign OPC_WE   = redir_q;
  assign OFLASH   = redir_q;
  assign ONEXT_PC = npc_q;
  assign OMODE    = mode_q;

endmodule
